// File: rtl/vc_dest_arbiter.sv
// Round-robin scheduler moving head words from VC0/VC1 into D0/D1.
// Tracks D-FIFO fill against the almost-full threshold and flags overflow.
module vc_dest_arbiter #(
    parameter int BITNUMBER  = 8,
    parameter int LENGTH     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DEST_BIT   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [LENGTH-1:0]    Umbral_D_in,
    input  logic                 VC0_empty,
    input  logic                 VC1_empty,
    input  logic [BITNUMBER-1:0] VC0_data,
    input  logic [BITNUMBER-1:0] VC1_data,
    input  logic [LENGTH-1:0]    D0_count,
    input  logic [LENGTH-1:0]    D1_count,
    output logic                 VC0_pop,
    output logic                 VC1_pop,
    output logic                 D0_push,
    output logic                 D1_push,
    output logic [BITNUMBER-1:0] data_out,
    output logic [2:0]           state,
    output logic                 idle,
    output logic                 error
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [LENGTH-1:0] DEPTH   = LENGTH'(FIFO_DEPTH);
    localparam logic [LENGTH:0]   DEPTH_W = (LENGTH+1)'(FIFO_DEPTH);

    state_t                 st;
    logic [LENGTH-1:0]      umbral_d;
    logic                   rr_ptr;
    logic [LENGTH:0]        limit;
    logic [LENGTH:0]        fill0;
    logic [LENGTH:0]        fill1;
    logic                   pause0;
    logic                   pause1;
    logic                   elig0;
    logic                   elig1;
    logic                   elig_any;
    logic                   overflow;
    logic                   grant_en;
    logic                   pop_any;
    logic                   push_pend;
    logic [BITNUMBER-1:0]   pick_data;
    logic                   pick_dest;
    logic [LENGTH-1:0]      umbral_clamp;

    // Registered push counts as already occupying a slot.
    assign limit  = DEPTH_W - {1'b0, umbral_d};
    assign fill0  = {1'b0, D0_count} + {{LENGTH{1'b0}}, D0_push};
    assign fill1  = {1'b0, D1_count} + {{LENGTH{1'b0}}, D1_push};
    assign pause0 = fill0 >= limit;
    assign pause1 = fill1 >= limit;

    assign elig0 = !VC0_empty && !(VC0_data[DEST_BIT] ? pause1 : pause0);
    assign elig1 = !VC1_empty && !(VC1_data[DEST_BIT] ? pause1 : pause0);
    assign elig_any = elig0 || elig1;

    assign overflow = (D0_push && D0_count >= DEPTH) ||
                      (D1_push && D1_count >= DEPTH);
    assign push_pend = D0_push || D1_push;
    assign grant_en  = (st == S_IDLE || st == S_ACTIVE) && !overflow;

    always_comb begin
        VC0_pop = 1'b0;
        VC1_pop = 1'b0;
        if (grant_en) begin
            if (elig0 && elig1) begin
                VC0_pop = rr_ptr;
                VC1_pop = !rr_ptr;
            end else begin
                VC0_pop = elig0;
                VC1_pop = elig1;
            end
        end
    end

    assign pop_any   = VC0_pop || VC1_pop;
    assign pick_data = VC1_pop ? VC1_data : VC0_data;
    assign pick_dest = pick_data[DEST_BIT];
    assign umbral_clamp = (Umbral_D_in > DEPTH) ? DEPTH : Umbral_D_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st       <= S_RESET;
            umbral_d <= '0;
            D0_push  <= 1'b0;
            D1_push  <= 1'b0;
            data_out <= '0;
            rr_ptr   <= 1'b0;
        end else begin
            D0_push <= pop_any && !pick_dest;
            D1_push <= pop_any && pick_dest;
            if (pop_any) begin
                data_out <= pick_data;
                rr_ptr   <= VC1_pop;
            end
            if (st == S_INIT && init)
                umbral_d <= umbral_clamp;
            if (st == S_RESET)
                st <= S_INIT;
            else if (init)
                st <= S_INIT;
            else if (overflow)
                st <= S_ERROR;
            else begin
                case (st)
                    S_INIT:   st <= S_IDLE;
                    S_IDLE:   if (elig_any) st <= S_ACTIVE;
                    S_ACTIVE: if (!elig_any && !push_pend) st <= S_IDLE;
                    default:  st <= st;
                endcase
            end
        end
    end

    assign state = st;
    assign idle  = (st == S_IDLE);
    assign error = (st == S_ERROR);

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Directed bench for vc_dest_arbiter: reset/init, single transfer,
// round-robin burst, threshold pause, overflow error and async reset.
module tb_vc_dest_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [7:0] Umbral_D_in;
    logic       VC0_empty;
    logic       VC1_empty;
    logic [7:0] VC0_data;
    logic [7:0] VC1_data;
    logic [7:0] D0_count;
    logic [7:0] D1_count;
    logic       VC0_pop;
    logic       VC1_pop;
    logic       D0_push;
    logic       D1_push;
    logic [7:0] data_out;
    logic [2:0] state;
    logic       idle;
    logic       error;

    int checks = 0;
    int errors = 0;

    vc_dest_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .Umbral_D_in (Umbral_D_in),
        .VC0_empty   (VC0_empty),
        .VC1_empty   (VC1_empty),
        .VC0_data    (VC0_data),
        .VC1_data    (VC1_data),
        .D0_count    (D0_count),
        .D1_count    (D1_count),
        .VC0_pop     (VC0_pop),
        .VC1_pop     (VC1_pop),
        .D0_push     (D0_push),
        .D1_push     (D1_push),
        .data_out    (data_out),
        .state       (state),
        .idle        (idle),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; init = 1'b0; Umbral_D_in = 8'd0;
        VC0_empty = 1'b1; VC1_empty = 1'b1;
        VC0_data = 8'h00; VC1_data = 8'h00;
        D0_count = 8'd0; D1_count = 8'd0;
        tick(); tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if ({D0_push, D1_push, idle, error} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {D0_push, D1_push, idle, error}); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
        checks++; if ({VC0_pop, VC1_pop} !== 2'b00) begin errors++; $display("FAIL reset_pops: got %b want 00", {VC0_pop, VC1_pop}); end
        reset = 1'b1; init = 1'b1; Umbral_D_in = 8'd2;
        tick();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL init_state: got %0d want 1", state); end
        tick();
        checks++; if (dut.umbral_d !== 8'd2) begin errors++; $display("FAIL umbral_load: got %0d want 2", dut.umbral_d); end
        init = 1'b0;
        tick();
        checks++; if (state !== 3'd2 || idle !== 1'b1) begin errors++; $display("FAIL init_to_idle: got %0d/%b want 2/1", state, idle); end
    endtask

    task automatic test_single();
        VC0_empty = 1'b0; VC0_data = 8'h05;
        #1;
        checks++; if ({VC0_pop, VC1_pop} !== 2'b10) begin errors++; $display("FAIL single_pop: got %b want 10", {VC0_pop, VC1_pop}); end
        tick();
        VC0_empty = 1'b1;
        checks++; if ({D0_push, D1_push} !== 2'b10 || data_out !== 8'h05) begin errors++; $display("FAIL single_push: got %b/%h want 10/05", {D0_push, D1_push}, data_out); end
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL single_active: got %0d want 3", state); end
        tick();
        checks++; if ({D0_push, D1_push} !== 2'b00) begin errors++; $display("FAIL single_once: got %b want 00", {D0_push, D1_push}); end
        tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL single_idle: got %0d want 2", state); end
    endtask

    task automatic test_round_robin();
        logic [7:0] w0 [4];
        logic [7:0] w1 [4];
        int i0 = 0;
        int i1 = 0;
        logic exp1;
        logic [7:0] exp_word;
        for (int j = 0; j < 4; j++) begin
            w0[j] = 8'h20 + 8'(j);
            w1[j] = 8'h30 + 8'(j);
        end
        for (int k = 0; k < 8; k++) begin
            VC0_empty = (i0 >= 4); VC0_data = w0[i0 < 4 ? i0 : 3];
            VC1_empty = (i1 >= 4); VC1_data = w1[i1 < 4 ? i1 : 3];
            #1;
            exp1 = (k % 2 == 0);
            exp_word = exp1 ? 8'h30 + 8'(k / 2) : 8'h20 + 8'(k / 2);
            checks++; if (VC1_pop !== exp1 || VC0_pop !== !exp1) begin errors++; $display("FAIL rr_pop[%0d]: got %b want %b", k, {VC0_pop, VC1_pop}, {!exp1, exp1}); end
            if (VC0_pop === 1'b1) i0++;
            if (VC1_pop === 1'b1) i1++;
            tick();
            checks++; if ({D0_push, D1_push} !== 2'b01 || data_out !== exp_word) begin errors++; $display("FAIL rr_push[%0d]: got %b/%h want 01/%h", k, {D0_push, D1_push}, data_out, exp_word); end
        end
        VC0_empty = 1'b1; VC1_empty = 1'b1;
        tick();
        checks++; if ({D0_push, D1_push} !== 2'b00) begin errors++; $display("FAIL rr_drain: got %b want 00", {D0_push, D1_push}); end
        tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL rr_idle: got %0d want 2", state); end
    endtask

    task automatic test_pause();
        D0_count = 8'd6; D1_count = 8'd0;
        VC0_empty = 1'b0; VC0_data = 8'h05;
        VC1_empty = 1'b0; VC1_data = 8'h25;
        #1;
        checks++; if ({VC0_pop, VC1_pop} !== 2'b01) begin errors++; $display("FAIL pause_hol: got %b want 01", {VC0_pop, VC1_pop}); end
        tick();
        checks++; if ({D0_push, D1_push} !== 2'b01 || data_out !== 8'h25) begin errors++; $display("FAIL pause_vc1: got %b/%h want 01/25", {D0_push, D1_push}, data_out); end
        VC1_empty = 1'b1; D0_count = 8'd5;
        #1;
        checks++; if ({VC0_pop, VC1_pop} !== 2'b10) begin errors++; $display("FAIL pause_below: got %b want 10", {VC0_pop, VC1_pop}); end
        tick();
        checks++; if ({D0_push, D1_push} !== 2'b10 || data_out !== 8'h05) begin errors++; $display("FAIL pause_d0push: got %b/%h want 10/05", {D0_push, D1_push}, data_out); end
        VC0_data = 8'h06;
        #1;
        checks++; if (VC0_pop !== 1'b0) begin errors++; $display("FAIL pause_inflight: got %b want 0", VC0_pop); end
        tick();
        D0_count = 8'd6;
        #1;
        checks++; if (VC0_pop !== 1'b0) begin errors++; $display("FAIL pause_full6: got %b want 0", VC0_pop); end
        VC0_empty = 1'b1; D0_count = 8'd0;
        tick(); tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL pause_idle: got %0d want 2", state); end
    endtask

    task automatic test_error();
        VC1_empty = 1'b0; VC1_data = 8'h25;
        #1;
        checks++; if (VC1_pop !== 1'b1) begin errors++; $display("FAIL err_pop: got %b want 1", VC1_pop); end
        tick();
        VC1_empty = 1'b1;
        D1_count = 8'd8;
        VC0_empty = 1'b0; VC0_data = 8'h01;
        #1;
        checks++; if ({VC0_pop, VC1_pop} !== 2'b00) begin errors++; $display("FAIL err_detect_pops: got %b want 00", {VC0_pop, VC1_pop}); end
        tick();
        checks++; if (state !== 3'd4 || error !== 1'b1) begin errors++; $display("FAIL err_state: got %0d/%b want 4/1", state, error); end
        checks++; if ({D0_push, D1_push} !== 2'b00) begin errors++; $display("FAIL err_push: got %b want 00", {D0_push, D1_push}); end
        checks++; if ({VC0_pop, VC1_pop} !== 2'b00) begin errors++; $display("FAIL err_pops: got %b want 00", {VC0_pop, VC1_pop}); end
        tick();
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL err_sticky: got %0d want 4", state); end
        init = 1'b1; Umbral_D_in = 8'd2;
        tick();
        checks++; if (state !== 3'd1 || error !== 1'b0) begin errors++; $display("FAIL err_init: got %0d/%b want 1/0", state, error); end
        init = 1'b0; VC0_empty = 1'b1; D1_count = 8'd0;
        tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL err_recover: got %0d want 2", state); end
    endtask

    task automatic test_async_reset();
        VC0_empty = 1'b0; VC0_data = 8'h07;
        #1;
        checks++; if (VC0_pop !== 1'b1) begin errors++; $display("FAIL ar_pop: got %b want 1", VC0_pop); end
        tick();
        checks++; if (D0_push !== 1'b1 || data_out !== 8'h07) begin errors++; $display("FAIL ar_push: got %b/%h want 1/07", D0_push, data_out); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({D0_push, D1_push} !== 2'b00 || data_out !== 8'h00) begin errors++; $display("FAIL ar_clear: got %b/%h want 00/00", {D0_push, D1_push}, data_out); end
        checks++; if (state !== 3'd0 || VC0_pop !== 1'b0) begin errors++; $display("FAIL ar_state: got %0d/%b want 0/0", state, VC0_pop); end
        tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL ar_hold: got %0d want 0", state); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pause();
        test_error();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
